// File: rtl/forwarding_hazard_unit.sv
// RAW hazard resolver: combinational per-port forwarding from the youngest matching producer; stalls Decode while that producer is not ready.
// Zero-cycle forward/stall path; the RUN/STALL/ERROR FSM and saturating counters are registered, and a stall timeout releases the pipeline.
module forwarding_hazard_unit #(
  parameter int DATA_WIDTH       = 32,
  parameter int REG_ADDR_WIDTH   = 5,
  parameter int NUM_READ_PORTS   = 2,
  parameter int NUM_FWD_STAGES   = 2,
  parameter int MAX_STALL_CYCLES = 8,
  parameter int COUNTER_WIDTH    = 16
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     flush,
  input  logic [NUM_READ_PORTS*REG_ADDR_WIDTH-1:0] readAddress_Decode,
  input  logic [NUM_READ_PORTS-1:0]                readUsed_Decode,
  input  logic [NUM_FWD_STAGES-1:0]                writeEnable_Stage,
  input  logic [NUM_FWD_STAGES*REG_ADDR_WIDTH-1:0] writeAddress_Stage,
  input  logic [NUM_FWD_STAGES*DATA_WIDTH-1:0]     writeData_Stage,
  input  logic [NUM_FWD_STAGES-1:0]                dataReady_Stage,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]     forwardData,
  output logic [NUM_READ_PORTS-1:0]                forwardValid,
  output logic                                     stallDecode,
  output logic                                     bubbleExecute,
  output logic [COUNTER_WIDTH-1:0]                 stallCount,
  output logic [COUNTER_WIDTH-1:0]                 forwardCount,
  output logic                                     hazardError
);

  localparam int SRW = $clog2(MAX_STALL_CYCLES + 1);
  localparam logic [SRW-1:0] MAX_RUN = SRW'(MAX_STALL_CYCLES);

  typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_ERROR} state_e;

  state_e                    state_q;
  logic [SRW-1:0]            stall_run_q;
  logic [COUNTER_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
  logic [COUNTER_WIDTH-1:0]  fwd_cnt_q, fwd_cnt_d;
  logic [NUM_READ_PORTS-1:0] blocked;
  logic                      hazard;

  // Scan oldest to youngest so the youngest matching stage overrides older ones.
  always_comb begin
    forwardValid = '0;
    forwardData  = '0;
    blocked      = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      for (int s = NUM_FWD_STAGES - 1; s >= 0; s--) begin
        if (readUsed_Decode[p] && writeEnable_Stage[s] &&
            (writeAddress_Stage[s*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] != '0) &&
            (writeAddress_Stage[s*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] ==
             readAddress_Decode[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH])) begin
          forwardValid[p] = dataReady_Stage[s];
          forwardData[p*DATA_WIDTH +: DATA_WIDTH] =
            dataReady_Stage[s] ? writeData_Stage[s*DATA_WIDTH +: DATA_WIDTH] : '0;
          blocked[p] = ~dataReady_Stage[s];
        end
      end
    end
  end

  assign hazard        = |blocked;
  assign stallDecode   = hazard & ~flush & (state_q != ST_ERROR);
  assign bubbleExecute = stallDecode;
  assign hazardError   = (state_q == ST_ERROR);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_RUN;
      stall_run_q <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (stallDecode) begin
            state_q     <= ST_STALL;
            stall_run_q <= SRW'(1);
          end
        end
        ST_STALL: begin
          if (flush || !hazard) begin
            state_q     <= ST_RUN;
            stall_run_q <= '0;
          end else if (stall_run_q == MAX_RUN) begin
            state_q <= ST_ERROR;
          end else begin
            stall_run_q <= stall_run_q + SRW'(1);
          end
        end
        ST_ERROR: state_q <= ST_ERROR;
        default: begin
          state_q     <= ST_RUN;
          stall_run_q <= '0;
        end
      endcase
    end
  end

  // Counters hold at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stallDecode && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + COUNTER_WIDTH'(1);
    if ((|forwardValid) && !(&fwd_cnt_q)) fwd_cnt_d = fwd_cnt_q + COUNTER_WIDTH'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stallCount   = stall_cnt_q;
  assign forwardCount = fwd_cnt_q;

endmodule
